// File: rtl/score_pkg.sv
// Shared scoreboard definitions: point codes used by the encoder, the adder
// and the display decoder, plus the encoder FSM state encoding.
package score_pkg;

  typedef logic [1:0] pts_t;

  localparam pts_t PTS_NONE = 2'd0;
  localparam pts_t PTS_1    = 2'd1;
  localparam pts_t PTS_2    = 2'd2;
  localparam pts_t PTS_3    = 2'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_OFFER    = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  // Bit 0 = +1 button, bit 1 = +2, bit 2 = +3; callers only use this on one-hot input.
  function automatic pts_t encode_press(input logic [2:0] press);
    pts_t code;
    code = PTS_NONE;
    if (press[0])      code = PTS_1;
    else if (press[1]) code = PTS_2;
    else if (press[2]) code = PTS_3;
    return code;
  endfunction

  function automatic logic multi_hot(input logic [2:0] press);
    return (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button: 2-FF synchronizer, stability counter, debounced level and a
// single-cycle pulse on each debounced press.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic             pressed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign pressed  = ~sync_p1;
  assign cnt_next = cnt + CNT_W'(1);

  // Stage p0/p1: synchronizer, idles at the released (high) level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= raw_n;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: level flips on the edge that completes DEBOUNCE_CYCLES differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (pressed != level) begin
        if (cnt_next == CNT_MAX) begin
          level <= pressed;
          rise  <= pressed;
          cnt   <= '0;
        end else begin
          cnt <= cnt_next;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/score_button_encoder.sv
// Scoreboard front end: turns three debounced point buttons into single
// point-code events offered to the score adder over valid/ready.
module score_button_encoder
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_a_n,
  input  logic       btn_b_n,
  input  logic       btn_c_n,
  input  logic       sub_sw,
  output logic [1:0] points,
  output logic       points_sub,
  output logic       points_valid,
  input  logic       points_ready,
  output logic       multi_press,
  output logic       busy
);

  logic [2:0] level_p2;
  logic [2:0] press_p2;
  logic [1:0] state;

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst   (rst),
    .raw_n (btn_a_n),
    .level (level_p2[0]),
    .rise  (press_p2[0])
  );

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst   (rst),
    .raw_n (btn_b_n),
    .level (level_p2[1]),
    .rise  (press_p2[1])
  );

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
    .clk   (clk),
    .rst   (rst),
    .raw_n (btn_c_n),
    .level (level_p2[2]),
    .rise  (press_p2[2])
  );

  assign busy = (state != ST_IDLE);

  // Stage p3: event FSM; anything arriving outside IDLE is dropped, never queued
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      points       <= PTS_NONE;
      points_sub   <= 1'b0;
      points_valid <= 1'b0;
      multi_press  <= 1'b0;
    end else begin
      multi_press <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (multi_hot(press_p2)) begin
            multi_press <= 1'b1;
            state       <= ST_WAIT_REL;
          end else if (press_p2 != 3'b000) begin
            points       <= encode_press(press_p2);
            points_sub   <= sub_sw;
            points_valid <= 1'b1;
            state        <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (points_ready) begin
            points       <= PTS_NONE;
            points_valid <= 1'b0;
            state        <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (level_p2 == 3'b000) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
